lsu_mmio: RTL and testbench
===========================

LSU_MMIO -- requirements
Module: lsu_mmio

Interface
REQ-001 SHALL have parameter DATA_W, default 64, data path width in bits (32 or 64).
REQ-002 SHALL have parameter RAM_AW, default 10, RAM word-address width.
REQ-003 SHALL have parameter MMIO_BASE, default 'h78, byte address of MMIO register 0, aligned to DATA_W/8.
REQ-004 SHALL have parameter MMIO_N, default 4, number of DATA_W-bit MMIO registers, range 1..16.
REQ-005 SHALL have port sys_clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port sys_rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port req_valid, input, 1 bit: request present.
REQ-008 SHALL have port req_ready, output, 1 bit: request can be accepted.
REQ-009 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-010 SHALL have port req_size, input, 2 bits: 0 = byte, 1 = half, 2 = word, 3 = double.
REQ-011 SHALL have port req_unsigned, input, 1 bit: zero-extend the load result when 1, sign-extend when 0.
REQ-012 SHALL have port req_addr, input, 32 bits: byte address.
REQ-013 SHALL have port req_wdata, input, DATA_W bits: store data, right-aligned.
REQ-014 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-015 SHALL have port rsp_rdata, output, DATA_W bits: extended load data.
REQ-016 SHALL have port rsp_err, output, 1 bit: misaligned or unsupported-size request.
REQ-017 SHALL have RAM ports ram_en (out, 1), ram_we (out, DATA_W/8), ram_addr (out, RAM_AW), ram_wdata (out, DATA_W) and ram_rdata (in, DATA_W); the RAM is synchronous with 1-cycle read latency.
REQ-018 SHALL have port mmio_regs, output, MMIO_N*DATA_W bits: all MMIO registers, with register 0 in the LSBs.

Function
REQ-019 SHALL implement FSM states IDLE, ACCESS, RDATA and RESP; req_ready=1 only in IDLE.
REQ-020 SHALL register all request fields on acceptance (req_valid && req_ready) and move IDLE->ACCESS.
REQ-021 SHALL compute byte offset off = addr[log2(DATA_W/8)-1:0] and byte count n = 1<<size.
REQ-022 SHALL form lane mask = ((1<<n)-1) << off and replicate store data across lanes according to size.
REQ-023 SHALL flag an error when off is not a multiple of n, or when size=3 with DATA_W=32.
REQ-024 SHALL, for an error request in ACCESS, perform no RAM or MMIO access and go to RESP with rsp_err=1 and rsp_rdata=0.
REQ-025 SHALL classify a request as an MMIO hit when MMIO_BASE <= addr < MMIO_BASE + MMIO_N*DATA_W/8; the index is (addr-MMIO_BASE)/(DATA_W/8).
REQ-026 SHALL, for an MMIO store in ACCESS, update reg = (reg & ~mask) | (data & mask), keep ram_en=0, and go to RESP.
REQ-027 SHALL, for an MMIO load in ACCESS, capture the register without touching the RAM and go to RESP.
REQ-028 SHALL, for a RAM store in ACCESS, assert ram_en=1, ram_we=mask, ram_addr=addr[RAM_AW+log2(DATA_W/8)-1:log2(DATA_W/8)] and ram_wdata=replicated data, then go to RESP.
REQ-029 SHALL, for a RAM load in ACCESS, assert ram_en=1 and ram_we=0, go to RDATA, and capture ram_rdata in RDATA before going to RESP.
REQ-030 SHALL produce load data by shifting right by off*8, truncating to n bytes and extending per req_unsigned; store responses have rsp_rdata=0.
REQ-031 SHALL, in RESP, hold rsp_valid=1 for exactly one cycle and then return to IDLE.
REQ-032 SHALL produce latency from acceptance to rsp_valid of 2 cycles for stores, MMIO accesses and errors, and 3 cycles for RAM loads.
REQ-033 SHALL drive ram_en=0 and ram_we=0 in every state other than ACCESS and RDATA.
REQ-034 SHALL have no response backpressure; a new request is accepted no earlier than the cycle after RESP.
REQ-035 SHALL treat address bits above the RAM range as ignored for RAM accesses (address wrap-around).

Reset
REQ-036 SHALL, with sys_rst=1 at a clock edge, set state=IDLE, all mmio_regs=0, rsp_valid=0, rsp_err=0 and rsp_rdata=0.
REQ-037 SHALL, when reset is asserted mid-operation, abandon the request with no response and no further RAM write; req_ready=1 on the first cycle after reset is released.

Verification
REQ-038 SHALL verify: sb addr 0x13 data 0xAB -> ram_we=0x08, ram_addr=2, ram_wdata=0xABAB..AB, then rsp_valid 2 cycles after acceptance.
REQ-039 SHALL verify: ld-half signed addr 0x16 with RAM word 0x8001_0000_0000_0000 -> rsp_rdata=0xFFFF_FFFF_FFFF_8001 after 3 cycles; the same load unsigned -> 0x8001.
REQ-040 SHALL verify: sw addr 0x84 data 0x12345678 -> mmio_regs[127:64]=0x12345678_00000000 with ram_en=0 throughout.
REQ-041 SHALL verify: lw addr 0x0A -> rsp_err=1, rsp_rdata=0, no RAM enable, rsp_valid 2 cycles after acceptance.
REQ-042 SHALL verify: reset asserted in the RDATA cycle -> no rsp_valid, mmio_regs=0, req_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/lsu_mmio.sv
// lsu_mmio: load/store unit steering aligned requests to a sync RAM or a small MMIO register file.
module lsu_mmio #(
  parameter int          DATA_W    = 64,
  parameter int          RAM_AW    = 10,
  parameter logic [31:0] MMIO_BASE = 32'h78,
  parameter int          MMIO_N    = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [31:0]              req_addr,
  input  logic [DATA_W-1:0]        req_wdata,
  output logic                     rsp_valid,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic                     rsp_err,
  output logic                     ram_en,
  output logic [DATA_W/8-1:0]      ram_we,
  output logic [RAM_AW-1:0]        ram_addr,
  output logic [DATA_W-1:0]        ram_wdata,
  input  logic [DATA_W-1:0]        ram_rdata,
  output logic [MMIO_N*DATA_W-1:0] mmio_regs
);
  localparam int NB = DATA_W / 8;
  localparam int OW = $clog2(NB);
  localparam logic [32:0] MMIO_END = {1'b0, MMIO_BASE} + 33'(MMIO_N * NB);
  localparam logic [1:0] IDLE = 2'd0, ACCESS = 2'd1, RDATA = 2'd2, RESP = 2'd3;
  logic [1:0]        r_state;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_err;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] r_mmio [MMIO_N];
  logic [OW-1:0]     w_off;
  logic [3:0]        w_n;
  logic              w_err;
  logic              w_hit;
  logic [3:0]        w_idx;
  logic [NB-1:0]     w_mask;
  logic [DATA_W-1:0] w_bmask;
  logic [DATA_W-1:0] w_rep;
  logic [DATA_W-1:0] w_vmask;
  logic [DATA_W-1:0] w_top;
  logic [DATA_W-1:0] w_src;
  logic [DATA_W-1:0] w_sh;
  logic              w_sign;
  logic [DATA_W-1:0] w_ld;
  assign w_off = r_addr[OW-1:0];
  assign w_n   = 4'd1 << r_size;
  assign w_err = ((int'(w_off) & (int'(w_n) - 1)) != 0) || (r_size == 2'd3 && DATA_W == 32);
  assign w_hit = {1'b0, r_addr} >= {1'b0, MMIO_BASE} && {1'b0, r_addr} < MMIO_END;
  assign w_idx = 4'((r_addr - MMIO_BASE) >> OW);
  always_comb begin
    w_mask  = '0;
    w_bmask = '0;
    w_vmask = '0;
    w_rep   = '0;
    for (int i = 0; i < NB; i++) begin
      w_mask[i]         = i >= int'(w_off) && i < int'(w_off) + int'(w_n);
      w_bmask[i*8 +: 8] = {8{w_mask[i]}};
      w_vmask[i*8 +: 8] = {8{i < int'(w_n)}};
      w_rep[i*8 +: 8]   = r_size == 2'd0 ? r_wdata[7:0] :
                          r_size == 2'd1 ? r_wdata[(i%2)*8 +: 8] :
                          r_size == 2'd2 ? r_wdata[(i%4)*8 +: 8] : r_wdata[i*8 +: 8];
    end
  end
  always_comb begin
    w_src = ram_rdata;
    for (int k = 0; k < MMIO_N; k++)
      if (r_state != RDATA && int'(w_idx) == k) w_src = r_mmio[k];
  end
  // sign bit sits at the top of the valid-byte window after right-justifying
  assign w_sh   = w_src >> {w_off, 3'b000};
  assign w_top  = w_vmask & ~(w_vmask >> 1);
  assign w_sign = ~r_uns & |(w_sh & w_top);
  assign w_ld   = (w_sh & w_vmask) | ({DATA_W{w_sign}} & ~w_vmask);
  assign req_ready = r_state == IDLE;
  assign rsp_valid = r_state == RESP;
  assign rsp_err   = r_err;
  assign rsp_rdata = r_rdata;
  assign ram_en    = r_state == ACCESS && !w_err && !w_hit;
  assign ram_we    = ram_en && r_we ? w_mask : '0;
  assign ram_addr  = r_addr[RAM_AW+OW-1:OW];
  assign ram_wdata = w_rep;
  always_comb begin
    mmio_regs = '0;
    for (int k = 0; k < MMIO_N; k++) mmio_regs[k*DATA_W +: DATA_W] = r_mmio[k];
  end
  always_ff @(posedge sys_clk)
    if (r_state == IDLE && req_valid) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_uns   <= req_unsigned;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      r_state <= IDLE;
      r_err   <= 1'b0;
      r_rdata <= '0;
      for (int k = 0; k < MMIO_N; k++) r_mmio[k] <= '0;
    end else begin
      case (r_state)
        IDLE:
          if (req_valid) begin
            r_state <= ACCESS;
            r_err   <= 1'b0;
            r_rdata <= '0;
          end
        ACCESS: begin
          r_state <= (w_err || w_hit || r_we) ? RESP : RDATA;
          r_err   <= w_err;
          if (!w_err && w_hit && !r_we) r_rdata <= w_ld;
          for (int k = 0; k < MMIO_N; k++)
            if (!w_err && w_hit && r_we && int'(w_idx) == k)
              r_mmio[k] <= (r_mmio[k] & ~w_bmask) | (w_rep & w_bmask);
        end
        RDATA: begin
          r_state <= RESP;
          r_rdata <= w_ld;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_lsu_mmio.sv
// tb_lsu_mmio: random and directed requests checked against a byte-level memory model.
module tb_lsu_mmio;
  logic        clk = 1'b0;
  logic        sys_rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr;
  logic [63:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  logic        ram_en;
  logic [7:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [63:0] ram_wdata, ram_rdata;
  logic [255:0] mmio_regs;
  lsu_mmio dut (
    .sys_clk(clk), .sys_rst(sys_rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .mmio_regs(mmio_regs)
  );
  always #5 clk = ~clk;
  logic [63:0] ram_mem [1024];
  int          en_cnt = 0;
  logic [7:0]  l_we;
  logic [9:0]  l_addr;
  logic [63:0] l_wdata;
  always @(posedge clk)
    if (ram_en) begin
      for (int b = 0; b < 8; b++)
        if (ram_we[b]) ram_mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      ram_rdata <= ram_mem[ram_addr];
      en_cnt    <= en_cnt + 1;
      l_we      <= ram_we;
      l_addr    <= ram_addr;
      l_wdata   <= ram_wdata;
    end
  logic [7:0]  m_ram [8192];
  logic [7:0]  m_io  [32];
  int          n_cmp = 0, n_bad = 0;
  logic [63:0] last_data;
  logic        last_err;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic bit is_io(input logic [31:0] a);
    return a >= 32'h78 && a < 32'h98;
  endfunction
  task automatic chk_io(input string tag);
    logic [63:0] e;
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 8; b++) e[b*8 +: 8] = m_io[r*8 + b];
      chk(tag, mmio_regs[r*64 +: 64], e);
    end
  endtask
  task automatic req(input string tag, input logic we, input logic [1:0] sz, input logic un,
                     input logic [31:0] a, input logic [63:0] d);
    int n, lat, en0;
    bit e_err, io;
    logic [63:0] e_data;
    n = 1 << sz;
    e_err = (a % n) != 0;
    io = is_io(a);
    e_data = '0;
    if (!e_err) begin
      for (int b = 0; b < n; b++)
        if (we) begin
          if (io) m_io[int'(a - 32'h78) + b] = d[8*b +: 8];
          else m_ram[int'((a + b) & 32'h1FFF)] = d[8*b +: 8];
        end else
          e_data[8*b +: 8] = io ? m_io[int'(a - 32'h78) + b] : m_ram[int'((a + b) & 32'h1FFF)];
      if (!we && !un && e_data[8*n-1])
        for (int b = n; b < 8; b++) e_data[8*b +: 8] = 8'hFF;
    end
    @(negedge clk);
    chk({tag, "_ready"}, req_ready, 1);
    req_valid = 1; req_we = we; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = d;
    en0 = en_cnt;
    @(posedge clk);
    #1 req_valid = 0;
    lat = 0;
    for (int c = 1; c <= 6 && lat == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        last_data = rsp_rdata;
        last_err = rsp_err;
      end
    end
    chk({tag, "_lat"}, lat, (!e_err && !io && !we) ? 3 : 2);
    chk({tag, "_data"}, last_data, e_data);
    chk({tag, "_err"}, last_err, e_err);
    chk({tag, "_ram_en"}, en_cnt - en0, (!e_err && !io) ? 1 : 0);
    @(negedge clk);
    chk({tag, "_pulse"}, rsp_valid, 0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    logic [31:0] a;
    int seen;
    sys_rst = 1; req_valid = 0; req_we = 0; req_size = 0; req_unsigned = 0; req_addr = 0; req_wdata = 0;
    for (int i = 0; i < 1024; i++) ram_mem[i] = '0;
    for (int i = 0; i < 8192; i++) m_ram[i] = '0;
    for (int i = 0; i < 32; i++) m_io[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    sys_rst = 0;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk_io("rst_mmio");
    req("sb", 1, 0, 0, 32'h13, 64'hAB);
    chk("sb_we", l_we, 8'h08);
    chk("sb_addr", l_addr, 2);
    chk("sb_wdata", l_wdata, 64'hABAB_ABAB_ABAB_ABAB);
    req("sd", 1, 3, 0, 32'h10, 64'h8001_0000_0000_0000);
    req("lh_s", 0, 1, 0, 32'h16, 0);
    chk("lh_s_val", last_data, 64'hFFFF_FFFF_FFFF_8001);
    req("lh_u", 0, 1, 1, 32'h16, 0);
    chk("lh_u_val", last_data, 64'h8001);
    req("sw_io", 1, 2, 0, 32'h84, 64'h1234_5678);
    chk("sw_io_reg1", mmio_regs[127:64], 64'h1234_5678_0000_0000);
    req("lw_mis", 0, 2, 0, 32'h0A, 0);
    chk("lw_mis_err", last_err, 1);
    req("sd_io_top", 1, 3, 0, 32'h90, 64'hDEAD_BEEF_0BAD_F00D);
    req("sd_above", 1, 3, 0, 32'h98, 64'h1111_2222_3333_4444);
    req("sb_below", 1, 0, 0, 32'h77, 64'h5A);
    req("ld_io_top", 0, 3, 0, 32'h90, 0);
    req("ld_above", 0, 3, 0, 32'h98, 0);
    req("lb_below", 0, 0, 0, 32'h77, 0);
    req("sb_wrap", 1, 0, 0, 32'h2010, 64'hC3);
    req("lbu_wrap", 0, 0, 1, 32'h10, 0);
    chk("wrap_val", last_data, 64'hC3);
    chk_io("dir_mmio");
    for (int t = 0; t < 300; t++) begin
      a = $urandom_range(0, 255);
      if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_E000);
      req("rnd", 1'($urandom), 2'($urandom), 1'($urandom), a, {$urandom, $urandom});
      chk_io("rnd_mmio");
    end
    req("sw_pre", 1, 2, 0, 32'h78, 64'hCAFE_F00D);
    @(negedge clk);
    req_valid = 1; req_we = 0; req_size = 3; req_unsigned = 0; req_addr = 32'h20;
    @(posedge clk);
    #1 req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1;
    seen = 0;
    @(negedge clk);
    sys_rst = 0;
    if (rsp_valid) seen++;
    chk("mid_rst_ready", req_ready, 1);
    for (int i = 0; i < 32; i++) m_io[i] = '0;
    chk_io("mid_rst_mmio");
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("mid_rst_no_rsp", seen, 0);
    chk("mid_rst_ready2", req_ready, 1);
    req("post_sw", 1, 2, 0, 32'h8C, 64'h0BEE_F123);
    req("post_ld", 0, 3, 1, 32'h20, 0);
    chk_io("post_mmio");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
